// File: rtl/div_pow2m1_serial.sv
// Digit-serial unsigned divider by D = 2^K - 1: end-around digit sum gives the
// remainder, then an LSB-first exact division of (x - r) by D gives the quotient.
module div_pow2m1_serial #(
   parameter int W = 32,
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] x,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q,
   output logic [K-1:0] r,
   output logic         exact
);
   localparam int N  = W / K;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, SUM, FOLD, DIV, DONE} state_t;
   state_t state, nxt;

   logic [W-1:0]   opnd;
   logic [W-K-1:0] qsh;
   logic [W-1:0]   qcat;
   logic [K-1:0]   acc, rsh, digit, qprev, alu_a, alu_b, acc_n, fold_r;
   logic [K:0]     alu;
   logic           borrow, alu_ci, last;
   logic [CW-1:0]  cnt;

   // Operand rotates right one digit per cycle, so after N digits it is intact again
   assign digit = opnd[K-1:0];
   assign qprev = qsh[W-K-1 -: K];
   assign last  = (cnt == CW'(N - 1));
   assign qcat  = {alu[K-1:0], qsh};

   // Shared K-bit adder: acc + d in SUM, q_prev + ~t + ~b (i.e. q_prev - t - b) in DIV
   always_comb begin
      alu_a  = acc;
      alu_b  = digit;
      alu_ci = 1'b0;
      if (state == DIV) begin
         alu_a  = qprev;
         alu_b  = ~digit;
         alu_ci = ~borrow;
      end
      alu = {1'b0, alu_a} + {1'b0, alu_b} + {{K{1'b0}}, alu_ci};
   end

   assign acc_n  = alu[K-1:0] + {{(K-1){1'b0}}, alu[K]};
   assign fold_r = (&acc) ? '0 : acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt  = state;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: if (start) nxt = SUM;
         SUM: begin
            busy = 1'b1;
            if (last) nxt = FOLD;
         end
         FOLD: begin
            busy = 1'b1;
            nxt  = DIV;
         end
         DIV: begin
            busy = 1'b1;
            if (last) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opnd   <= '0;
         acc    <= '0;
         rsh    <= '0;
         qsh    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         q      <= '0;
         r      <= '0;
         exact  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               opnd <= x;
               acc  <= '0;
               cnt  <= '0;
            end
            SUM: begin
               acc  <= acc_n;
               opnd <= {opnd[K-1:0], opnd[W-1:K]};
               cnt  <= cnt + CW'(1);
            end
            FOLD: begin
               rsh    <= fold_r;
               opnd   <= opnd - {{(W-K){1'b0}}, fold_r};
               qsh    <= '0;
               borrow <= 1'b0;
               cnt    <= '0;
            end
            DIV: begin
               qsh    <= qcat[W-1:K];
               borrow <= ~alu[K];
               opnd   <= {opnd[K-1:0], opnd[W-1:K]};
               cnt    <= cnt + CW'(1);
               // Visible results move only on DONE entry; qcat already holds the top digit
               if (last) begin
                  q     <= qcat;
                  r     <= rsh;
                  exact <= (rsh == '0);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
